alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Multi-cycle integer execution unit that consumes the 4-bit `alu_control` code produced by the ALU decoder and computes the RV32I ALU result. Operands and control are accepted over a valid/ready handshake. Results are returned over a second valid/ready handshake. Shifts run on a one-bit-per-cycle iterative shifter to save area; all other operations complete in a single cycle. The unit sits between operand fetch and writeback/branch resolution in the multi-cycle core.

## Interface
- `WIDTH`, default 32: datapath width. Shift amount is `src_b[4:0]`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operand/control beat presented.
- `in_ready` output 1: unit can accept a beat; equals (state == IDLE).
- `alu_control` input 4: operation code, sampled on accept.
- `src_a` input WIDTH: operand A, sampled on accept.
- `src_b` input WIDTH: operand B, sampled on accept.
- `out_valid` output 1: result beat presented.
- `out_ready` input 1: consumer accepts result.
- `result` output WIDTH: registered result.
- `zero` output 1: registered (result == 0); used for beq/bne.
- `illegal` output 1: registered; set when the accepted code is 1100–1111.

## Operation
- Codes:
  - 0000 ADD: a+b, mod 2^WIDTH.
  - 0001 SUB: a−b, mod 2^WIDTH.
  - 0010 SLL.
  - 0011 SLT: signed a<b.
  - 0100 SLTU: unsigned a<b.
  - 0101 XOR.
  - 0110 SRL.
  - 0111 SRA.
  - 1000 OR.
  - 1001 AND.
  - 1010 SGE: signed a>=b.
  - 1011 SGEU: unsigned a>=b.
  - 1100–1111: result 0, `illegal`=1.
- Compare ops return 1 or 0, zero-extended to WIDTH.
- Accept occurs on an edge where `in_valid && in_ready`.
- States:
  - IDLE: `in_ready`=1.
    - On accept of a non-shift op, or a shift with shamt=0: latch result, `zero`, and `illegal`; go to DONE.
    - On accept of a shift with shamt n≥1: load shift register with `src_a`, set count=n, latch op; go to SHIFT.
  - SHIFT: each edge shifts by one bit and decrements count.
    - SLL fills 0; SRL fills 0; SRA fills the original sign bit.
    - When count becomes 0, latch the final value into `result`/`zero`, clear `illegal`, and go to DONE.
  - DONE: `out_valid`=1. `result`, `zero`, and `illegal` are held stable until an edge with `out_ready`=1, then go to IDLE.
- `in_valid` while not IDLE is ignored; operands are not captured.
- Only one operation is in flight at a time. No pipelining.
- `zero` and `illegal` are meaningful only while `out_valid`=1.

## Timing
- Reset values (asserted asynchronously, immediately):
  - state = IDLE, `in_ready`=1.
  - `out_valid`=0, `result`=0, `zero`=0, `illegal`=0.
  - Shift count = 0.
- Reset mid-SHIFT or mid-DONE aborts the operation. No result is ever presented for it.
- Latency, measured from the accept edge E:
  - Non-shift op, or shamt=0: `out_valid` is high in the cycle after E.
  - Shift with shamt n: `out_valid` rises after edge E+n. Maximum is n=31, i.e. 31 cycles.
- `out_ready` may be held high in advance. DONE then lasts exactly one cycle, and `in_ready` returns the following cycle.
- Minimum throughput: one operation per 2 cycles (accept cycle plus DONE cycle).
- `out_ready` low stalls DONE indefinitely. Outputs must not change during the stall.
- `in_ready` is combinational from state only; there is no combinational path from `in_valid` or `out_ready`.

## Test plan
- Reset: assert `reset` mid-SHIFT (SLL, shamt=20, after 5 cycles) → `out_valid`=0, `in_ready`=1, `result`=0 immediately; no stale result after reset release.
- Single-cycle ops: ADD 0x7FFFFFFF+1 → `result`=0x80000000, `zero`=0. SUB 5−5 → `result`=0, `zero`=1. SLT −1<1 → 1. SLTU 0xFFFFFFFF<1 → 0. SGEU 0xFFFFFFFF>=1 → 1. Each has `out_valid` the cycle after accept.
- Iterative shifts: SRA 0x80000000 by 31 → 0xFFFFFFFF with `out_valid` 31 edges after accept. SRL of the same → 0x00000001. SLL 1 by 0 → 1 with 1-cycle latency. `src_b`=0x25 shifts by 5.
- Backpressure: hold `out_ready`=0 for 10 cycles after XOR 0xF0F0F0F0^0xFFFFFFFF → `result`=0x0F0F0F0F stable and `in_ready`=0 throughout; a new `in_valid` beat is ignored; one result is delivered when `out_ready` rises.
- Illegal code 1110 with a=3, b=4 → `result`=0, `zero`=1, `illegal`=1. The next legal op (AND 0xC, 0xA = 0x8) clears `illegal`.
- Streaming: random 1000 ops with random `in_valid`/`out_ready` → results match the reference model in order, and the number of results equals the number of accepts.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// Handshake bundle for alu_exec_unit: operand beat in, result beat out.
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  // Producer of operands / consumer of results.
  modport master (
    output in_valid, alu_control, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  // The execution unit itself.
  modport slave (
    input  in_valid, alu_control, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Multi-cycle RV32I ALU: single-cycle ops resolve on accept, shifts iterate one bit per cycle.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  alu_exec_unit_if.slave bus_io
);

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b0001;
  localparam logic [3:0] OpSll  = 4'b0010;
  localparam logic [3:0] OpSlt  = 4'b0011;
  localparam logic [3:0] OpSltu = 4'b0100;
  localparam logic [3:0] OpXor  = 4'b0101;
  localparam logic [3:0] OpSrl  = 4'b0110;
  localparam logic [3:0] OpSra  = 4'b0111;
  localparam logic [3:0] OpOr   = 4'b1000;
  localparam logic [3:0] OpAnd  = 4'b1001;
  localparam logic [3:0] OpSge  = 4'b1010;
  localparam logic [3:0] OpSgeu = 4'b1011;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic             is_shift;
  logic [4:0]       shamt;
  logic             lt_s, lt_u;
  logic [WIDTH-1:0] shift_next;
  logic             shift_fill;

  assign shamt = bus_io.src_b[4:0];
  assign lt_s  = $signed(bus_io.src_a) < $signed(bus_io.src_b);
  assign lt_u  = bus_io.src_a < bus_io.src_b;

  // Single-cycle result for the presented operands; shifts here only cover shamt == 0.
  always_comb begin
    alu_res  = '0;
    alu_ill  = 1'b0;
    is_shift = 1'b0;
    case (bus_io.alu_control)
      OpAdd:  alu_res = bus_io.src_a + bus_io.src_b;
      OpSub:  alu_res = bus_io.src_a - bus_io.src_b;
      OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, lt_s};
      OpSltu: alu_res = {{(WIDTH-1){1'b0}}, lt_u};
      OpXor:  alu_res = bus_io.src_a ^ bus_io.src_b;
      OpOr:   alu_res = bus_io.src_a | bus_io.src_b;
      OpAnd:  alu_res = bus_io.src_a & bus_io.src_b;
      OpSge:  alu_res = {{(WIDTH-1){1'b0}}, ~lt_s};
      OpSgeu: alu_res = {{(WIDTH-1){1'b0}}, ~lt_u};
      OpSll, OpSrl, OpSra: begin
        is_shift = 1'b1;
        alu_res  = bus_io.src_a;
      end
      default: alu_ill = 1'b1;
    endcase
  end

  // One-bit shift step; for SRA the MSB never changes, so it still holds the original sign.
  always_comb begin
    shift_fill = (op_q == OpSra) & shreg_q[WIDTH-1];
    if (op_q == OpSll) begin
      shift_next = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin
      shift_next = {shift_fill, shreg_q[WIDTH-1:1]};
    end
  end

  // Next-state and datapath update for the accept / shift / present sequence.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.in_valid) begin
          if (is_shift && (shamt != 5'd0)) begin
            shreg_d = bus_io.src_a;
            cnt_d   = shamt;
            op_d    = bus_io.alu_control;
            state_d = StShift;
          end else begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = alu_ill;
            state_d   = StDone;
          end
        end
      end
      StShift: begin
        shreg_d = shift_next;
        cnt_d   = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          result_d  = shift_next;
          zero_d    = (shift_next == '0);
          illegal_d = 1'b0;
          state_d   = StDone;
        end
      end
      StDone: begin
        if (bus_io.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      shreg_q   <= '0;
      cnt_q     <= 5'd0;
      op_q      <= 4'd0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
    end
  end

  assign bus_io.in_ready  = (state_q == StIdle);
  assign bus_io.out_valid = (state_q == StDone);
  assign bus_io.result    = result_q;
  assign bus_io.zero      = zero_q;
  assign bus_io.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed vector table, multi-cycle corner sequences and a random streaming run.
module tb_alu_exec_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_exec_unit_if #(.WIDTH(32)) bus ();

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          lat;  // edges from accept (inclusive) until out_valid is seen
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    logic        ill;
    ill = 1'b0;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a << b[4:0];
      4'd3:  r = {31'd0, $signed(a) < $signed(b)};
      4'd4:  r = {31'd0, a < b};
      4'd5:  r = a ^ b;
      4'd6:  r = a >> b[4:0];
      4'd7:  r = $signed(a) >>> b[4:0];
      4'd8:  r = a | b;
      4'd9:  r = a & b;
      4'd10: r = {31'd0, $signed(a) >= $signed(b)};
      4'd11: r = {31'd0, a >= b};
      default: begin
        r   = 32'd0;
        ill = 1'b1;
      end
    endcase
    return {ill, r};
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    @(negedge clk);
    chk($sformatf("v%0d in_ready before accept", idx), {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid    = 1'b1;
    bus.alu_control = v.op;
    bus.src_a       = v.a;
    bus.src_b       = v.b;
    bus.out_ready   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.src_a    = 32'hDEAD_BEEF;
    bus.src_b    = 32'h1234_5678;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d latency", idx), lat, v.lat);
    chk($sformatf("v%0d result", idx), bus.result, v.res);
    chk($sformatf("v%0d zero", idx), {31'd0, bus.zero}, {31'd0, v.z});
    chk($sformatf("v%0d illegal", idx), {31'd0, bus.illegal}, {31'd0, v.ill});
    @(negedge clk);
    chk($sformatf("v%0d out_valid after done", idx), {31'd0, bus.out_valid}, 32'd0);
    chk($sformatf("v%0d in_ready after done", idx), {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    int          delivered;
    int          accepts;
    int          results;
    int          cyc;
    int          lat;
    logic [32:0] q[$];
    logic [32:0] e;

    checks = 0;
    errors = 0;
    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.alu_control = 4'd0;
    bus.src_a       = 32'd0;
    bus.src_b       = 32'd0;
    bus.out_ready   = 1'b0;

    //               op     a             b             res           z     ill   lat
    vecs[0]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1};
    vecs[1]  = '{4'd1,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1};
    vecs[2]  = '{4'd3,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1};
    vecs[3]  = '{4'd4,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1};
    vecs[4]  = '{4'd11, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1};
    vecs[5]  = '{4'd10, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1};
    vecs[6]  = '{4'd10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1};
    vecs[7]  = '{4'd7,  32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, 1'b0, 32};
    vecs[8]  = '{4'd6,  32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0, 32};
    vecs[9]  = '{4'd2,  32'h00000001, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 1};
    vecs[10] = '{4'd2,  32'h00000001, 32'h00000025, 32'h00000020, 1'b0, 1'b0, 6};
    vecs[11] = '{4'd5,  32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F, 1'b0, 1'b0, 1};
    vecs[12] = '{4'd8,  32'h0000000C, 32'h0000000A, 32'h0000000E, 1'b0, 1'b0, 1};
    vecs[13] = '{4'd14, 32'h00000003, 32'h00000004, 32'h00000000, 1'b1, 1'b1, 1};
    vecs[14] = '{4'd9,  32'h0000000C, 32'h0000000A, 32'h00000008, 1'b0, 1'b0, 1};
    vecs[15] = '{4'd7,  32'h80000010, 32'h00000004, 32'hF8000001, 1'b0, 1'b0, 5};
    vecs[16] = '{4'd6,  32'h000000F0, 32'h00000004, 32'h0000000F, 1'b0, 1'b0, 5};
    vecs[17] = '{4'd3,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1};
    vecs[18] = '{4'd4,  32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1};
    vecs[19] = '{4'd2,  32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 32};

    // Reset values.
    repeat (2) @(negedge clk);
    chk("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset result", bus.result, 32'd0);
    chk("reset zero", {31'd0, bus.zero}, 32'd0);
    chk("reset illegal", {31'd0, bus.illegal}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      run_vec(i, vecs[i]);
    end

    // Reset mid-shift: SLL by 20, five cycles in.
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.alu_control = 4'd2;
    bus.src_a       = 32'h00000001;
    bus.src_b       = 32'd20;
    bus.out_ready   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("midshift in_ready low", {31'd0, bus.in_ready}, 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("midshift reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midshift reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("midshift reset result", bus.result, 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    delivered = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.out_valid) delivered++;
    end
    chk("midshift no stale result", delivered, 0);

    // Backpressure on a XOR result, with an extra beat offered during the stall.
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.alu_control = 4'd5;
    bus.src_a       = 32'hF0F0F0F0;
    bus.src_b       = 32'hFFFFFFFF;
    bus.out_ready   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.alu_control = 4'd0;
    bus.src_a       = 32'h00000001;
    bus.src_b       = 32'h00000001;
    delivered       = 0;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("stall%0d out_valid", c), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("stall%0d result", c), bus.result, 32'h0F0F0F0F);
      chk($sformatf("stall%0d in_ready", c), {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (bus.out_valid && bus.out_ready) delivered++;
      @(negedge clk);
    end
    chk("stall single delivery", delivered, 1);
    chk("stall in_ready after", {31'd0, bus.in_ready}, 32'd1);

    // Random streaming against the reference model.
    accepts = 0;
    results = 0;
    cyc     = 0;
    while ((accepts < 1000 || q.size() > 0) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (accepts < 1000) begin
        bus.in_valid    = 1'($urandom_range(0, 1));
        bus.alu_control = 4'($urandom_range(0, 15));
        bus.src_a       = $urandom;
        bus.src_b       = ($urandom_range(0, 3) == 0) ? bus.src_a : $urandom;
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(ref_alu(bus.alu_control, bus.src_a, bus.src_b));
        accepts++;
      end
      if (bus.out_valid && bus.out_ready) begin
        results++;
        if (q.size() == 0) begin
          chk("stream unexpected result", {31'd0, bus.out_valid}, 32'd0);
        end else begin
          e = q.pop_front();
          chk($sformatf("stream%0d result", results), bus.result, e[31:0]);
          chk($sformatf("stream%0d zero", results), {31'd0, bus.zero},
              {31'd0, e[31:0] == 32'd0});
          chk($sformatf("stream%0d illegal", results), {31'd0, bus.illegal}, {31'd0, e[32]});
        end
      end
    end
    lat = q.size();
    chk("stream accepts", accepts, 1000);
    chk("stream results equal accepts", results, accepts);
    chk("stream queue drained", lat, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
